regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 80 ++++++++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register file / scoreboard slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_NRD   = 2;
  localparam int RF_NWR   = 1;
  localparam int RF_AW    = $clog2(RF_NREGS);
  localparam int RF_CW    = $clog2(RF_NREGS + 1);

  typedef logic [RF_AW-1:0]   rf_addr_t;
  typedef logic [RF_XLEN-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register plus a running popcount.
// Latency: issue/write-back take effect on the next rising edge; outputs are registered.
// Backpressure: none; every strobe is accepted every cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   iss_en, iss_rd      issue strobe and destination (sets the busy bit)
//   wb_en, wb_addr      write-back strobes and destinations (clear busy bits)
//   busy_vec, busy_cnt  registered busy bits and their population count
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = RF_NREGS,
  parameter  int NWR   = RF_NWR,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic [NWR-1:0]         wb_en,
  input  logic [NWR-1:0][AW-1:0] wb_addr,
  output logic [NREGS-1:0]       busy_vec,
  output logic [CW-1:0]          busy_cnt
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] busy_nxt;
  logic             inc;
  logic [CW-1:0]    dec;
  logic             dup;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    dec      = '0;
    dup      = 1'b0;

    // Register 0 never has a producer.
    if (iss_en && iss_rd != '0) set_mask[iss_rd] = 1'b1;

    for (int p = 0; p < NWR; p++) begin
      if (wb_en[p] && wb_addr[p] != '0) clr_mask[wb_addr[p]] = 1'b1;
    end

    // Set beats clear so a same-cycle reissue keeps the bit for the new producer.
    busy_nxt = (busy_vec & ~clr_mask) | set_mask;

    // Count only real 0->1 and 1->0 transitions so the counter tracks busy_vec
    // without recomputing its popcount.
    inc = |(set_mask & ~busy_vec);

    for (int p = 0; p < NWR; p++) begin
      // A lower port aimed at the same register as a higher port is the same
      // clear; count it once (on the highest port).
      dup = 1'b0;
      for (int q = p + 1; q < NWR; q++) begin
        if (wb_en[q] && wb_addr[q] == wb_addr[p]) dup = 1'b1;
      end
      if (wb_en[p] && wb_addr[p] != '0 && busy_vec[wb_addr[p]] &&
          !set_mask[wb_addr[p]] && !dup)
        dec = dec + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      busy_cnt <= busy_cnt + {{(CW-1){1'b0}}, inc} - dec;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with an attached pending-write scoreboard.
// Latency: reads are combinational; writes land on the next edge (same cycle with RF_BYPASS_EN).
// Backpressure: none; all reads, issues and write-backs are accepted every cycle.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rs_addr/rs_data/rs_busy read addresses, read data, pending-producer flags
//   wb_en/wb_addr/wb_data   write-back ports (higher index wins on collision)
//   iss_en/iss_rd           issue strobe and destination register
//   busy_vec/busy_cnt       registered scoreboard bits and their popcount
// Build option: define RF_BYPASS_EN to forward same-cycle write-back data to reads.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN,
  parameter  int NREGS = RF_NREGS,
  parameter  int NRD   = RF_NRD,
  parameter  int NWR   = RF_NWR,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NRD-1:0][AW-1:0]   rs_addr,
  output logic [NRD-1:0][XLEN-1:0] rs_data,
  output logic [NRD-1:0]           rs_busy,
  input  logic [NWR-1:0]           wb_en,
  input  logic [NWR-1:0][AW-1:0]   wb_addr,
  input  logic [NWR-1:0][XLEN-1:0] wb_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_rd,
  output logic [NREGS-1:0]         busy_vec,
  output logic [CW-1:0]            busy_cnt
);

  logic [XLEN-1:0] mem [NREGS];

  // Ports are applied in ascending order so the last (highest-indexed)
  // nonblocking write to a register wins. Entry 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wb_en[p] && wb_addr[p] != '0) mem[wb_addr[p]] <= wb_data[p];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rs_data[r] = '0;
      rs_busy[r] = (rs_addr[r] != '0) && busy_vec[rs_addr[r]];
      if (rs_addr[r] != '0) rs_data[r] = mem[rs_addr[r]];
`ifdef RF_BYPASS_EN
      // Forwarding is suppressed in reset so reads are 0 while rst_n is low.
      if (rst_n && rs_addr[r] != '0) begin
        for (int p = 0; p < NWR; p++) begin
          if (wb_en[p] && wb_addr[p] == rs_addr[r]) begin
            rs_data[r] = wb_data[p];
            rs_busy[r] = iss_en && (iss_rd == rs_addr[r]);
          end
        end
      end
`endif
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against an array-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_regfile_scoreboard;
  import rf_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0][4:0]  rs_addr;
  logic [1:0][31:0] rs_data;
  logic [1:0]       rs_busy;
  logic [1:0]       wb_en;
  logic [1:0][4:0]  wb_addr;
  logic [1:0][31:0] wb_data;
  logic             iss_en;
  logic [4:0]       iss_rd;
  logic [31:0]      busy_vec;
  logic [5:0]       busy_cnt;

  logic [31:0] ref_mem [32];
  bit          ref_busy [32];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NWR(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_reset();
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]  = '0;
      ref_busy[i] = 1'b0;
    end
  endfunction

  // Winning write-back port for a register this cycle, or -1.
  function automatic int wb_hit(input int a);
    for (int p = 1; p >= 0; p--)
      if (wb_en[p] && wb_addr[p] != 0 && int'(wb_addr[p]) == a) return p;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    if (!rst_n || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (wb_hit(a) >= 0) return wb_data[wb_hit(a)];
`endif
    return ref_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!rst_n || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (wb_hit(a) >= 0) return iss_en && int'(iss_rd) == a;
`endif
    return ref_busy[a];
  endfunction

  function automatic logic [31:0] ref_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = ref_busy[i];
    return v;
  endfunction

  function automatic int ref_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += ref_busy[i];
    return c;
  endfunction

  // Architectural effect of one clock edge.
  function automatic void ref_edge();
    if (!rst_n) return;
    for (int p = 0; p < 2; p++) begin
      if (wb_en[p] && wb_addr[p] != 0) begin
        ref_mem[wb_addr[p]]  = wb_data[p];
        ref_busy[wb_addr[p]] = 1'b0;
      end
    end
    if (iss_en && iss_rd != 0) ref_busy[iss_rd] = 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_comb();
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("rs_data%0d[a=%0d]", r, rs_addr[r]), rs_data[r], exp_rd(rs_addr[r]));
      chk($sformatf("rs_busy%0d[a=%0d]", r, rs_addr[r]), rs_busy[r], exp_busy(rs_addr[r]));
    end
  endtask

  task automatic check_regs();
    chk("busy_vec", busy_vec, ref_vec());
    chk("busy_cnt", busy_cnt, ref_cnt());
  endtask

  // Inputs are already set; check reads, clock once, check registered state.
  task automatic step();
    #1 check_comb();
    @(posedge clk);
    ref_edge();
    #1 check_regs();
  endtask

  task automatic idle();
    wb_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic rand_in();
    wb_en      = 2'($urandom_range(0, 3));
    wb_addr[0] = 5'($urandom_range(0, 31));
    wb_addr[1] = ($urandom_range(0, 3) == 0) ? wb_addr[0] : 5'($urandom_range(0, 31));
    wb_data[0] = $urandom;
    wb_data[1] = $urandom;
    iss_en     = 1'($urandom_range(0, 1));
    iss_rd     = ($urandom_range(0, 3) == 0) ? wb_addr[0] : 5'($urandom_range(0, 31));
    rs_addr[0] = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 3))
      0: rs_addr[1] = wb_addr[1];
      1: rs_addr[1] = wb_addr[0];
      2: rs_addr[1] = iss_rd;
      default: rs_addr[1] = 5'($urandom_range(0, 31));
    endcase
  endtask

  initial begin
    rst_n   = 1'b0;
    rs_addr = '0;
    wb_addr = '0;
    wb_data = '0;
    iss_rd  = '0;
    idle();
    ref_reset();
    repeat (2) @(posedge clk);
    #1 check_regs();
    check_comb();
    rst_n = 1'b1;

    // Three consecutive issues, then reissue + write-back of r4.
    idle();
    iss_en = 1'b1;
    iss_rd = 5'd3; step(); chk("cnt_after_r3", busy_cnt, 64'd1);
    iss_rd = 5'd4; step(); chk("cnt_after_r4", busy_cnt, 64'd2);
    iss_rd = 5'd5; step(); chk("cnt_after_r5", busy_cnt, 64'd3);
    iss_rd = 5'd4; wb_en = 2'b01; wb_addr[0] = 5'd4; wb_data[0] = 32'h0000_4444;
    step();
    chk("reissue_busy4", busy_vec[4], 64'd1);
    chk("reissue_cnt", busy_cnt, 64'd3);

    // Register 0 is immune to issue and write-back.
    iss_rd = 5'd0; wb_addr[0] = 5'd0; wb_data[0] = 32'h0000_FFFF;
    step();
    idle(); rs_addr[0] = 5'd0;
    #1 chk("r0_read", rs_data[0], 64'd0);
    chk("r0_busy_bit", busy_vec[0], 64'd0);
    chk("r0_cnt_same", busy_cnt, 64'd3);
    step();

    // Same-cycle read of a write-back target.
    wb_en = 2'b01; wb_addr[0] = 5'd5; wb_data[0] = 32'hDEAD_BEEF; rs_addr[0] = 5'd5;
`ifdef RF_BYPASS_EN
    #1 chk("bypass_same_cycle", rs_data[0], 64'hDEAD_BEEF);
`else
    #1 chk("no_bypass_same_cycle", rs_data[0], 64'd0);
`endif
    step();
    idle();
    #1 chk("wb_next_cycle", rs_data[0], 64'hDEAD_BEEF);
    step();

    // Both write ports to r7: higher port wins.
    wb_en = 2'b11; wb_addr[0] = 5'd7; wb_addr[1] = 5'd7;
    wb_data[0] = 32'h1111; wb_data[1] = 32'h2222;
    step();
    idle(); rs_addr[0] = 5'd7;
    #1 chk("dual_wb_r7", rs_data[0], 64'h2222);
    step();

    for (int i = 0; i < 5000; i++) begin
      rand_in();
      step();
    end

    // Mid-run asynchronous reset, away from any edge.
    #2 rst_n = 1'b0;
    ref_reset();
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd7;
    #1 chk("arst_vec", busy_vec, 64'd0);
    chk("arst_cnt", busy_cnt, 64'd0);
    check_comb();
    // Traffic presented during reset must be dropped.
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step();
    end
    #2 rst_n = 1'b1;

    for (int i = 0; i < 5000; i++) begin
      rand_in();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
